// File: rtl/alu_ctrl_stage.sv
// Registered ALU control decoder for the ID/EX boundary. Undefined encodings
// raise a sticky trap that bubbles the stage until flushed.
//
// state | meaning
// RUN   | decoding and accepting instructions
// TRAP  | undefined encoding seen; inputs ignored, bubbles until flush
module alu_ctrl_stage #(
  parameter int FUNC_W = 6,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              trap,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t            state, state_nxt;
  logic              out_valid_nxt, illegal_nxt;
  logic [CTRL_W-1:0] alu_ctrl_nxt;
  logic [CNT_W-1:0]  illegal_cnt_nxt;
  logic [3:0]        code;
  logic              legal;
  logic              upper_set;
  logic [5:0]        key;

  assign key       = func[5:0];
  assign upper_set = (func >> 6) != '0;

  always_comb begin
    code  = 4'd0;
    legal = 1'b0;
    unique case (alu_op)
      2'b10: begin
        legal = 1'b1;
        case (key)
          6'b100000: code = 4'd1;
          6'b100010: code = 4'd2;
          6'b100100: code = 4'd3;
          6'b100101: code = 4'd4;
          6'b100110: code = 4'd5;
          6'b100011: code = 4'd6;
          6'b100111: code = 4'd7;
          6'b101000: code = 4'd8;
          6'b000000: code = 4'd0;
          default:   legal = 1'b0;
        endcase
      end
      2'b00: begin
        legal = 1'b1;
        case (key)
          6'b001000: code = 4'd1;
          6'b001100: code = 4'd3;
          6'b001101: code = 4'd4;
          6'b001110: code = 4'd5;
          6'b001001: code = 4'd8;
          6'b100011: code = 4'd1;
          6'b101011: code = 4'd1;
          6'b000011: code = 4'd10;
          6'b000100: code = 4'd11;
          default:   legal = 1'b0;
        endcase
      end
      2'b11: begin
        legal = 1'b1;
        code  = 4'd9;
      end
      default: legal = 1'b0;
    endcase
    // Branch-compare ignores func entirely, so wide-func bits only matter elsewhere.
    if (alu_op != 2'b11 && upper_set) legal = 1'b0;
    if (!legal) code = 4'd0;
  end

  always_comb begin
    state_nxt       = state;
    out_valid_nxt   = out_valid;
    alu_ctrl_nxt    = alu_ctrl;
    illegal_nxt     = illegal;
    illegal_cnt_nxt = illegal_cnt;
    if (flush) begin
      state_nxt     = RUN;
      out_valid_nxt = 1'b0;
      alu_ctrl_nxt  = '0;
      illegal_nxt   = 1'b0;
    end else if (!stall) begin
      out_valid_nxt = 1'b0;
      alu_ctrl_nxt  = '0;
      illegal_nxt   = 1'b0;
      if (state == RUN && in_valid) begin
        out_valid_nxt = 1'b1;
        if (legal) begin
          alu_ctrl_nxt = CTRL_W'(code);
        end else begin
          illegal_nxt = 1'b1;
          state_nxt   = TRAP;
          if (illegal_cnt != '1) illegal_cnt_nxt = illegal_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      out_valid   <= 1'b0;
      alu_ctrl    <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      state       <= state_nxt;
      out_valid   <= out_valid_nxt;
      alu_ctrl    <= alu_ctrl_nxt;
      illegal     <= illegal_nxt;
      illegal_cnt <= illegal_cnt_nxt;
    end
  end

  assign trap = (state == TRAP);

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
module tb_alu_ctrl_stage;

  localparam int FUNC_W = 8;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 2;

  typedef struct {
    logic             ov;
    logic [CTRL_W-1:0] ctrl;
    logic             ill;
    logic             trp;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        alu_op = 2'b00;
  logic [FUNC_W-1:0] func = '0;
  logic              out_valid;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              trap;
  logic [CNT_W-1:0]  illegal_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_ctrl_stage #(.FUNC_W(FUNC_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .func(func), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .trap(trap), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  // Drive one cycle and queue what the outputs must show after this edge.
  task automatic step(input string tag, input logic r, input logic iv, input logic st,
                      input logic fl, input logic [1:0] op, input logic [FUNC_W-1:0] fn,
                      input logic e_ov, input int e_ctrl, input logic e_ill,
                      input logic e_trp, input int e_cnt);
    exp_t e;
    rst = r; in_valid = iv; stall = st; flush = fl; alu_op = op; func = fn;
    e.ov = e_ov; e.ctrl = CTRL_W'(e_ctrl); e.ill = e_ill; e.trp = e_trp;
    e.cnt = CNT_W'(e_cnt); e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "out_valid", int'(out_valid), int'(e.ov));
        chk(e.tag, "alu_ctrl", int'(alu_ctrl), int'(e.ctrl));
        chk(e.tag, "illegal", int'(illegal), int'(e.ill));
        chk(e.tag, "trap", int'(trap), int'(e.trp));
        chk(e.tag, "illegal_cnt", int'(illegal_cnt), int'(e.cnt));
      end
    end
  end

  initial begin : driver
    int budget;
    //          tag        rst iv st fl op     func     ov ctrl ill trp cnt
    step("reset0",    1, 0, 0, 0, 2'b00, 8'h00,   0, 0,  0, 0, 0);
    step("reset1",    1, 1, 0, 0, 2'b10, 8'h22,   0, 0,  0, 0, 0);
    step("sub",       0, 1, 0, 0, 2'b10, 8'h22,   1, 2,  0, 0, 0);
    step("movi",      0, 1, 0, 0, 2'b00, 8'h09,   1, 8,  0, 0, 0);
    step("jc",        0, 1, 0, 0, 2'b00, 8'h03,   1, 10, 0, 0, 0);
    step("sw",        0, 1, 0, 0, 2'b00, 8'h2B,   1, 1,  0, 0, 0);
    step("add",       0, 1, 0, 0, 2'b10, 8'h20,   1, 1,  0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 0, 1, 1, 0, 2'b10, 8'h24, 1, 1, 0, 0, 0);
    step("and",       0, 1, 0, 0, 2'b10, 8'h24,   1, 3,  0, 0, 0);
    step("bubble",    0, 0, 0, 0, 2'b10, 8'h24,   0, 0,  0, 0, 0);
    step("nop",       0, 1, 0, 0, 2'b10, 8'h00,   1, 0,  0, 0, 0);
    step("cmp",       0, 1, 0, 0, 2'b10, 8'h27,   1, 7,  0, 0, 0);
    step("andi",      0, 1, 0, 0, 2'b00, 8'h0C,   1, 3,  0, 0, 0);
    step("jz",        0, 1, 0, 0, 2'b00, 8'h04,   1, 11, 0, 0, 0);
    // Reserved class traps; legal ops are ignored until flush.
    step("rsvd",      0, 1, 0, 0, 2'b01, 8'h00,   1, 0,  1, 1, 1);
    step("trap_ign0", 0, 1, 0, 0, 2'b10, 8'h20,   0, 0,  0, 1, 1);
    step("trap_ign1", 0, 1, 0, 0, 2'b10, 8'h20,   0, 0,  0, 1, 1);
    step("trap_stall",0, 1, 1, 0, 2'b10, 8'h20,   0, 0,  0, 1, 1);
    step("flush_drop",0, 1, 0, 1, 2'b10, 8'h20,   0, 0,  0, 0, 1);
    step("post_flush",0, 1, 0, 0, 2'b10, 8'h22,   1, 2,  0, 0, 1);
    // Upper func bit set; stall right after the illegal op holds it.
    step("wide_ill",  0, 1, 0, 0, 2'b10, 8'h60,   1, 0,  1, 1, 2);
    step("ill_stall", 0, 1, 1, 0, 2'b10, 8'h20,   1, 0,  1, 1, 2);
    step("trap_bub",  0, 0, 0, 0, 2'b10, 8'h20,   0, 0,  0, 1, 2);
    step("flush2",    0, 0, 0, 1, 2'b00, 8'h00,   0, 0,  0, 0, 2);
    step("branch",    0, 1, 0, 0, 2'b11, 8'hFF,   1, 9,  0, 0, 2);
    step("ill00",     0, 1, 0, 0, 2'b00, 8'h22,   1, 0,  1, 1, 3);
    step("flush3",    0, 0, 0, 1, 2'b00, 8'h00,   0, 0,  0, 0, 3);
    step("ill10_sat", 0, 1, 0, 0, 2'b10, 8'h2B,   1, 0,  1, 1, 3);
    step("flush_stall",0,0, 1, 1, 2'b00, 8'h00,   0, 0,  0, 0, 3);
    step("or",        0, 1, 0, 0, 2'b10, 8'h25,   1, 4,  0, 0, 3);
    step("fl_st_live",0, 1, 1, 1, 2'b10, 8'h25,   0, 0,  0, 0, 3);
    // Reset in the middle of a trap clears the counter too.
    step("rsvd2",     0, 1, 0, 0, 2'b01, 8'h3F,   1, 0,  1, 1, 3);
    step("rst_trap",  1, 1, 0, 0, 2'b10, 8'h26,   0, 0,  0, 0, 0);
    step("xor",       0, 1, 0, 0, 2'b10, 8'h26,   1, 5,  0, 0, 0);
    step("idle",      0, 0, 0, 0, 2'b00, 8'h00,   0, 0,  0, 0, 0);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #6;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Parametrised, registered successor to the combinational ALU control decoder. It sits at the ID/EX boundary of the 5-stage pipeline. It decodes the ALU op class (alu_op) and the function/opcode field (func) into an ALU control code, and registers the result with valid, stall and flush handling. It also detects undefined encodings, raises a sticky trap, bubbles the stage until flushed, and counts illegal ops. The old decoder held a latch on undefined encodings; this block does not.

Parameters:
FUNC_W, 6, width of func field; must be >= 6. Decode keys are the low 6 bits. Any set bit above bit 5 makes the op illegal.
CTRL_W, 4, width of alu_ctrl; must be >= 4. Codes are zero-extended.
CNT_W, 8, width of the saturating illegal-op counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  ID stage presents an instruction
stall  in  1  hold stage contents (EX not ready / hazard)
flush  in  1  kill stage contents, clear trap
alu_op  in  2  op class: 10 R-type, 00 I-type/mem/jump, 11 branch-compare, 01 reserved
func  in  FUNC_W  function field (R-type) or opcode (class 00)
out_valid  out  1  registered alu_ctrl is a live instruction
alu_ctrl  out  CTRL_W  registered ALU control code
illegal  out  1  registered: current out slot held an undefined encoding
trap  out  1  FSM in TRAP state
illegal_cnt  out  CNT_W  count of accepted illegal ops, saturating

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, alu_ctrl=0, illegal=0, trap=0, illegal_cnt=0, FSM=RUN.
- Priority at each posedge: rst > flush > stall > load.
- Latency: exactly 1 cycle from an accepted input to the outputs. Accept condition: in_valid & !stall & !flush & FSM==RUN.
- Decode for class 10 (func in binary -> code):
  - 100000 -> 1 ADD, 100010 -> 2 SUB, 100100 -> 3 AND, 100101 -> 4 OR
  - 100110 -> 5 XOR, 100011 -> 6 NOT, 100111 -> 7 CMP, 101000 -> 8 MOV
  - 000000 -> 0 NOP
- Decode for class 00:
  - 001000 -> 1 ADDI, 001100 -> 3 ANDI, 001101 -> 4 ORI, 001110 -> 5 XORI
  - 001001 -> 8 MOVI, 100011 -> 1 LW, 101011 -> 1 SW
  - 000011 -> 10 JC, 000100 -> 11 JZ
- Decode for class 11: code 9, func ignored (upper-bit check also skipped).
- Illegal cases: class 01, any func not listed for classes 10/00, or any nonzero func bit >= 6 in classes 10/00.
- Decode is fully combinational with a default branch; no latches.
- FSM RUN:
  - Accepted legal op: out_valid=1, alu_ctrl=code, illegal=0.
  - Accepted illegal op: out_valid=1, alu_ctrl=0, illegal=1, illegal_cnt+1 (saturates at all-ones), next=TRAP.
  - in_valid=0 and no stall: out_valid=0, alu_ctrl=0, illegal=0 (bubble).
- FSM TRAP:
  - trap=1. Inputs are ignored and the counter does not increment.
  - First non-stalled cycle after entry: out_valid=0, alu_ctrl=0, illegal=0. Bubbles continue thereafter.
  - Stays in TRAP until flush.
- stall=1 (no flush): all outputs, FSM state and counter hold. in_valid is ignored; the upstream stage holds its instruction.
- flush=1: out_valid=0, alu_ctrl=0, illegal=0, FSM=RUN, trap=0. illegal_cnt is kept. Any input in the same cycle is dropped.
- flush and stall together: flush wins.
- Reset mid-trap: full reset, counter cleared.

Test Plan:
1. Reset, then in_valid=1, alu_op=10, func=100010 -> next cycle out_valid=1, alu_ctrl=2, illegal=0, trap=0.
2. Back-to-back class 00 inputs 001001, 000011, 101011 with no stall -> alu_ctrl 8, 10, 1 on consecutive cycles; out_valid held at 1.
3. alu_op=10, func=100000, then stall=1 for 3 cycles with func changed to 100100 -> alu_ctrl stays 1 for all 3 cycles. After stall drops, next accept gives 3.
4. alu_op=01 -> out_valid=1, illegal=1, alu_ctrl=0, illegal_cnt=1. Next cycle trap=1, out_valid=0. A legal op is then ignored. Flush -> trap=0, counter stays 1, next legal op decodes.
5. FUNC_W=8, alu_op=10, func=0x60 (low bits 100000, bit 6 set) -> illegal=1. alu_op=11 with func=0xFF -> alu_ctrl=9, illegal=0.
6. CNT_W=2: four illegal ops, each followed by a flush -> illegal_cnt 1, 2, 3, 3 (saturates). flush and stall asserted together -> out_valid=0.
